// File: rtl/can_destuff_ctrl.sv
// Receive-side CAN bit destuffer: tracks equal-polarity runs while stuffing is active,
// removes the stuff bit that follows a full run and flags a sticky error when it is missing.
module can_destuff_ctrl #(
  parameter int unsigned STUFF_LEN = 5,
  parameter int unsigned CNT_W     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SP,
  input  logic             RX,
  input  logic             F_STF,
  input  logic             err_clr,
  output logic             sp_decision,
  output logic             bit_out,
  output logic             stuff_bit,
  output logic             stuff_err,
  output logic [CNT_W-1:0] run_cnt
);

  localparam logic [CNT_W-1:0] StuffLen = CNT_W'(STUFF_LEN);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StCount, StExpect, StErr} state_e;

  state_e           state_q;
  logic             last_q;
  logic [CNT_W-1:0] run_cnt_q;
  logic             sp_decision_q;
  logic             bit_out_q;
  logic             stuff_bit_q;
  logic             stuff_err_q;
  logic [CNT_W-1:0] run_inc;

  assign run_inc = run_cnt_q + CntOne;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      last_q        <= 1'b0;
      run_cnt_q     <= '0;
      sp_decision_q <= 1'b0;
      bit_out_q     <= 1'b0;
      stuff_bit_q   <= 1'b0;
      stuff_err_q   <= 1'b0;
    end else begin
      sp_decision_q <= 1'b0;
      stuff_bit_q   <= 1'b0;
      // Clear has priority; a coincident SP is dropped.
      if (err_clr) begin
        state_q     <= StIdle;
        run_cnt_q   <= '0;
        stuff_err_q <= 1'b0;
      end else if (SP) begin
        unique case (state_q)
          StIdle: begin
            sp_decision_q <= 1'b1;
            bit_out_q     <= RX;
            if (F_STF) begin
              last_q    <= RX;
              run_cnt_q <= CntOne;
              state_q   <= StCount;
            end
          end
          StCount: begin
            sp_decision_q <= 1'b1;
            bit_out_q     <= RX;
            if (!F_STF) begin
              run_cnt_q <= '0;
              state_q   <= StIdle;
            end else if (RX == last_q) begin
              run_cnt_q <= run_inc;
              if (run_inc == StuffLen) state_q <= StExpect;
            end else begin
              last_q    <= RX;
              run_cnt_q <= CntOne;
            end
          end
          // Checked regardless of F_STF so the stuff bit after the CRC is still removed.
          StExpect: begin
            if (RX != last_q) begin
              stuff_bit_q <= 1'b1;
              last_q      <= RX;
              if (F_STF) begin
                run_cnt_q <= CntOne;
                state_q   <= StCount;
              end else begin
                run_cnt_q <= '0;
                state_q   <= StIdle;
              end
            end else begin
              stuff_err_q <= 1'b1;
              state_q     <= StErr;
            end
          end
          StErr: begin
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign sp_decision = sp_decision_q;
  assign bit_out     = bit_out_q;
  assign stuff_bit   = stuff_bit_q;
  assign stuff_err   = stuff_err_q;
  assign run_cnt     = run_cnt_q;

endmodule

// File: tb/tb_can_destuff_ctrl.sv
// Scoreboard bench for can_destuff_ctrl: directed SP sequences push expected pulses,
// a negedge monitor pops and compares each sp_decision/stuff_bit pulse.
module tb_can_destuff_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       SP = 1'b0;
  logic       RX = 1'b0;
  logic       F_STF = 1'b0;
  logic       err_clr = 1'b0;
  logic       sp_decision;
  logic       bit_out;
  logic       stuff_bit;
  logic       stuff_err;
  logic [2:0] run_cnt;

  typedef struct packed {
    logic       is_stuff;
    logic       b;
    logic [2:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  can_destuff_ctrl #(.STUFF_LEN(5), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .SP         (SP),
    .RX         (RX),
    .F_STF      (F_STF),
    .err_clr    (err_clr),
    .sp_decision(sp_decision),
    .bit_out    (bit_out),
    .stuff_bit  (stuff_bit),
    .stuff_err  (stuff_err),
    .run_cnt    (run_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: every output pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (sp_decision || stuff_bit) begin
      exp_t e;
      n_vec++;
      if (sp_decision && stuff_bit) begin
        n_fail++;
        $display("FAIL pulse_excl: sp_decision=%0b stuff_bit=%0b, want not both", sp_decision,
                 stuff_bit);
      end else if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: sp_decision=%0b stuff_bit=%0b, want none", sp_decision,
                 stuff_bit);
      end else begin
        e = sb.pop_front();
        if (stuff_bit != e.is_stuff || (!e.is_stuff && bit_out != e.b) || run_cnt != e.cnt) begin
          n_fail++;
          $display("FAIL pulse: got stuff=%0b bit=%0b cnt=%0d, want stuff=%0b bit=%0b cnt=%0d",
                   stuff_bit, bit_out, run_cnt, e.is_stuff, e.b, e.cnt);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // kind: 0 = no pulse, 1 = data bit, 2 = stuff bit.
  task automatic sp(input logic f, input logic rx, input int kind, input logic [2:0] cnt);
    exp_t e;
    if (kind != 0) begin
      e.is_stuff = (kind == 2);
      e.b        = rx;
      e.cnt      = cnt;
      sb.push_back(e);
    end
    @(negedge clk);
    SP = 1'b1; RX = rx; F_STF = f;
    @(negedge clk);
    SP = 1'b0;
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL missing_pulse: %0d expected pulse(s) not seen, want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_sp_decision", {7'd0, sp_decision}, 8'd0);
    chk("rst_stuff_bit", {7'd0, stuff_bit}, 8'd0);
    chk("rst_stuff_err", {7'd0, stuff_err}, 8'd0);
    chk("rst_run_cnt", {5'd0, run_cnt}, 8'd0);
    reset = 1'b1;

    // 1: five zeros, stuff one, then a data zero.
    for (int i = 1; i <= 5; i++) sp(1'b1, 1'b0, 1, 3'(i));
    sp(1'b1, 1'b1, 2, 3'd1);
    sp(1'b1, 1'b0, 1, 3'd1);
    chk("t1_stuff_err", {7'd0, stuff_err}, 8'd0);

    // 2: six zeros -> stuff error, later SPs silent, run_cnt held at 5.
    sp(1'b0, 1'b1, 1, 3'd0);
    for (int i = 1; i <= 5; i++) sp(1'b1, 1'b0, 1, 3'(i));
    sp(1'b1, 1'b0, 0, 3'd0);
    chk("t2_stuff_err", {7'd0, stuff_err}, 8'd1);
    sp(1'b1, 1'b1, 0, 3'd0);
    sp(1'b1, 1'b0, 0, 3'd0);
    chk("t2_err_held", {7'd0, stuff_err}, 8'd1);
    chk("t2_cnt_nowrap", {5'd0, run_cnt}, 8'd5);

    // 6: err_clr together with SP wins, SP dropped.
    @(negedge clk);
    SP = 1'b1; RX = 1'b0; F_STF = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    SP = 1'b0; err_clr = 1'b0;
    #1;
    chk("t6_err_cleared", {7'd0, stuff_err}, 8'd0);
    chk("t6_cnt_cleared", {5'd0, run_cnt}, 8'd0);
    sp(1'b1, 1'b1, 1, 3'd1);

    // 3: stuffing off, eight zeros all pass with run_cnt 0.
    for (int i = 0; i < 8; i++) sp(1'b0, 1'b0, 1, 3'd0);
    chk("t3_stuff_err", {7'd0, stuff_err}, 8'd0);

    // 4: stuff bit after the region ends still removed, then back to IDLE.
    for (int i = 1; i <= 5; i++) sp(1'b1, 1'b1, 1, 3'(i));
    sp(1'b0, 1'b0, 2, 3'd0);
    sp(1'b0, 1'b1, 1, 3'd0);

    // 5: reset mid-run aborts the count.
    for (int i = 1; i <= 3; i++) sp(1'b1, 1'b1, 1, 3'(i));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5_cnt_in_reset", {5'd0, run_cnt}, 8'd0);
    chk("t5_dec_in_reset", {7'd0, sp_decision}, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) sp(1'b1, 1'b1, 1, 3'(i));

    // err_clr while counting returns run_cnt to 0.
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    chk("clr_in_count", {5'd0, run_cnt}, 8'd0);
    sp(1'b1, 1'b0, 1, 3'd1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
